// File: rtl/ascon_block_seq.sv
// Block/round sequencer for the ASCON core: walks AD and text blocks, runs the
// permutation round counter and emits the per-block control pulses.
module ascon_block_seq #(
   parameter int RATE_BYTES = 8,
   parameter int PA_ROUNDS  = 12,
   parameter int PB_ROUNDS  = 6
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        hash_mode_i,
   input  logic [31:0] ad_len_i,
   input  logic [31:0] text_len_i,
   input  logic        blk_valid_i,
   output logic        blk_ready_o,
   output logic [4:0]  blk_bytes_o,
   output logic        last_ad_block_o,
   output logic        last_text_block_o,
   output logic        last_ad_flag_clr_o,
   output logic        perm_busy_o,
   output logic        last_cc_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam int MAX_ROUNDS = (PA_ROUNDS > PB_ROUNDS) ? PA_ROUNDS : PB_ROUNDS;
   localparam int CNT_W      = $clog2(MAX_ROUNDS + 1);

   localparam logic [CNT_W-1:0] PA_CNT  = CNT_W'(PA_ROUNDS);
   localparam logic [CNT_W-1:0] PB_CNT  = CNT_W'(PB_ROUNDS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [31:0]      RATE_L  = 32'(RATE_BYTES);
   localparam logic [4:0]       RATE_B  = 5'(RATE_BYTES);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_INIT_P  = 4'd1;
   localparam logic [3:0] S_AD      = 4'd2;
   localparam logic [3:0] S_AD_P    = 4'd3;
   localparam logic [3:0] S_SEP     = 4'd4;
   localparam logic [3:0] S_TEXT    = 4'd5;
   localparam logic [3:0] S_TEXT_P  = 4'd6;
   localparam logic [3:0] S_FINAL_P = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_round_cnt;
   logic [31:0]      r_ad_rem;
   logic [31:0]      r_txt_rem;
   logic             r_hash;
   logic             r_ad_fin;
   logic             r_last_ad_block;
   logic             r_last_text_block;

   logic             w_perm_busy;
   logic             w_blk_ready;
   logic             w_accept;
   logic             w_ad_last;
   logic             w_txt_last;
   logic [31:0]      w_rem;
   logic [3:0]       w_perm_exit;

   assign w_perm_busy = (r_state == S_INIT_P) || (r_state == S_AD_P) ||
                        (r_state == S_TEXT_P) || (r_state == S_FINAL_P);
   assign w_blk_ready = (r_state == S_AD) || (r_state == S_TEXT);
   assign w_accept    = blk_valid_i & w_blk_ready;
   assign w_ad_last   = r_ad_rem < RATE_L;
   assign w_txt_last  = r_txt_rem < RATE_L;
   assign w_rem       = (r_state == S_TEXT) ? r_txt_rem : r_ad_rem;

   // Where each permutation lands once its final round completes.
   always_comb begin
      w_perm_exit = S_IDLE;
      case (r_state)
         S_INIT_P:  w_perm_exit = (!r_hash && (r_ad_rem == 32'd0)) ? S_SEP : S_AD;
         S_AD_P:    w_perm_exit = r_ad_fin ? S_SEP : S_AD;
         S_TEXT_P:  w_perm_exit = S_TEXT;
         S_FINAL_P: w_perm_exit = S_DONE;
         default:   w_perm_exit = S_IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state           <= S_IDLE;
         r_round_cnt       <= '0;
         r_ad_rem          <= '0;
         r_txt_rem         <= '0;
         r_hash            <= 1'b0;
         r_ad_fin          <= 1'b0;
         r_last_ad_block   <= 1'b0;
         r_last_text_block <= 1'b0;
      end else begin
         r_last_ad_block   <= 1'b0;
         r_last_text_block <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_ad_rem    <= ad_len_i;
                  r_txt_rem   <= text_len_i;
                  r_hash      <= hash_mode_i;
                  r_ad_fin    <= 1'b0;
                  r_round_cnt <= PA_CNT;
                  r_state     <= S_INIT_P;
               end
            end
            S_INIT_P, S_AD_P, S_TEXT_P, S_FINAL_P: begin
               r_round_cnt <= r_round_cnt - CNT_ONE;
               if (r_round_cnt == CNT_ONE) begin
                  r_state <= w_perm_exit;
               end
            end
            S_AD: begin
               if (w_accept) begin
                  if (w_ad_last) begin
                     r_last_ad_block <= 1'b1;
                     if (r_hash) begin
                        r_round_cnt <= PA_CNT;
                        r_state     <= S_FINAL_P;
                     end else begin
                        r_ad_fin    <= 1'b1;
                        r_round_cnt <= PB_CNT;
                        r_state     <= S_AD_P;
                     end
                  end else begin
                     r_ad_rem    <= r_ad_rem - RATE_L;
                     r_round_cnt <= r_hash ? PA_CNT : PB_CNT;
                     r_state     <= S_AD_P;
                  end
               end
            end
            S_SEP: r_state <= S_TEXT;
            S_TEXT: begin
               if (w_accept) begin
                  if (w_txt_last) begin
                     r_last_text_block <= 1'b1;
                     r_round_cnt       <= PA_CNT;
                     r_state           <= S_FINAL_P;
                  end else begin
                     r_txt_rem   <= r_txt_rem - RATE_L;
                     r_round_cnt <= PB_CNT;
                     r_state     <= S_TEXT_P;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign blk_ready_o        = w_blk_ready;
   assign blk_bytes_o        = !w_blk_ready ? 5'd0 :
                               (w_rem < RATE_L) ? w_rem[4:0] : RATE_B;
   assign last_ad_block_o    = r_last_ad_block;
   assign last_text_block_o  = r_last_text_block;
   assign last_ad_flag_clr_o = (r_state == S_SEP) || ((r_state == S_DONE) && r_hash);
   assign perm_busy_o        = w_perm_busy;
   assign last_cc_o          = w_perm_busy && (r_round_cnt == CNT_ONE);
   assign busy_o             = (r_state != S_IDLE);
   assign done_o             = (r_state == S_DONE);

endmodule
